// File: rtl/i2s_tdm_clock_pkg.sv
// Shared definitions for the I2S/TDM clocking, serialiser and deserialiser blocks.
// Frame-sync mode encodings, the clock generator state type and counter width helpers.
// Purely declarative; no logic lives here.
package i2s_pkg;

    // Frame-sync flavour: 50% duty word select, or one-bit pulse ahead of slot 0.
    localparam logic WS_I2S   = 1'b0;
    localparam logic WS_PULSE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } i2s_clk_state_t;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of a bit-within-frame index for a frame of slots*bits bits.
    function automatic int frame_w(input int slots, input int bits);
        return cnt_w(slots * bits);
    endfunction

endpackage

// File: rtl/i2s_tdm_clock.sv
// I2S/TDM bit-clock and frame-sync generator: divides ck down to sck and frames it with ws.
// Latency: running/frame_start one edge after en; first sck rise H+1 edges after entering RUN.
// No backpressure: a dropped en drains to the next frame boundary, en re-entry is phase-continuous.
module i2s_tdm_clock
    import i2s_pkg::*;
#(
    parameter int   CLK_DIV       = 4,
    parameter int   BITS_PER_SLOT = 32,
    parameter int   SLOTS         = 2,
    parameter logic WS_MODE       = WS_I2S
) (
    input  logic                                 ck,
    input  logic                                 rst,
    input  logic                                 en,
    output logic                                 sck,
    output logic                                 ws,
    output logic [$clog2(SLOTS*BITS_PER_SLOT)-1:0] frame_posn,
    output logic [$clog2(SLOTS)-1:0]             slot,
    output logic                                 sck_rise,
    output logic                                 sck_fall,
    output logic                                 frame_start,
    output logic                                 running
);

    localparam int FRAME = SLOTS * BITS_PER_SLOT;
    localparam int FW    = $clog2(FRAME);
    localparam int SW    = $clog2(SLOTS);
    localparam int DW    = cnt_w(CLK_DIV);
    localparam int H     = CLK_DIV / 2;

    localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(H);
    localparam logic [FW-1:0] FP_MAX   = FW'(FRAME - 1);
    localparam logic [FW-1:0] FP_HALF  = FW'(FRAME / 2);

    i2s_clk_state_t  state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [FW-1:0]   fp_q, fp_d;
    logic            sck_q, sck_d;
    logic            ws_q, ws_d;
    logic            sck_rise_q, sck_rise_d;
    logic            sck_fall_q, sck_fall_d;
    logic            frame_start_q, frame_start_d;

    logic            run_w;
    logic            div_wrap;
    logic            frame_wrap;

    assign run_w      = (state_q != ST_IDLE);
    assign div_wrap   = (div_q == DIV_MAX);
    assign frame_wrap = div_wrap && (fp_q == FP_MAX);

    // Next state and counters: count while active, park at zero while idle.
    always_comb begin
        state_d = state_q;
        div_d   = '0;
        fp_d    = '0;
        if (run_w) begin
            div_d = div_wrap ? '0 : div_q + DW'(1);
            fp_d  = div_wrap ? fp_q + FW'(1) : fp_q;
        end
        case (state_q)
            ST_IDLE:  if (en) state_d = ST_RUN;
            ST_RUN:   if (!en) state_d = ST_DRAIN;
            ST_DRAIN: begin
                // Re-entry leaves the counters alone so sck keeps its phase.
                if (en)              state_d = ST_RUN;
                else if (frame_wrap) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode from pre-edge counter values so sck, ws and strobes align.
    always_comb begin
        sck_d         = run_w && (div_q >= DIV_HALF);
        sck_rise_d    = run_w && (div_q == DIV_HALF) && !sck_q;
        // Not gated by state: the last fall after entering IDLE still gets a strobe.
        sck_fall_d    = (div_q == '0) && sck_q;
        frame_start_d = ((state_q == ST_RUN) && (div_q == '0) && (fp_q == '0) && sck_q)
                      || ((state_q == ST_IDLE) && en);
        if (WS_MODE == WS_PULSE) begin
            ws_d = run_w && (fp_q == FP_MAX);
        end else begin
            ws_d = run_w && (fp_q >= FP_HALF);
        end
    end

    // State, counters and registered outputs; reset drops everything without a drain.
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            div_q         <= '0;
            fp_q          <= '0;
            sck_q         <= 1'b0;
            ws_q          <= 1'b0;
            sck_rise_q    <= 1'b0;
            sck_fall_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            fp_q          <= fp_d;
            sck_q         <= sck_d;
            ws_q          <= ws_d;
            sck_rise_q    <= sck_rise_d;
            sck_fall_q    <= sck_fall_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign sck         = sck_q;
    assign ws          = ws_q;
    assign frame_posn  = fp_q;
    assign slot        = fp_q[FW-1 -: SW];
    assign sck_rise    = sck_rise_q;
    assign sck_fall    = sck_fall_q;
    assign frame_start = frame_start_q;
    assign running     = run_w;

endmodule

// File: tb/tb_i2s_tdm_clock.sv
// Directed bench for i2s_tdm_clock: an I2S stereo instance (div 4) and a TDM-8 pulse instance (div 6).
// Expected values come from closed-form waveforms indexed by edges since the IDLE->RUN edge.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_i2s_tdm_clock;
    import i2s_pkg::*;

    logic       ck;
    logic       rst;
    logic       en_a, en_b;
    logic       sck_a, ws_a, rise_a, fall_a, fs_a, run_a;
    logic [5:0] fp_a;
    logic [0:0] slot_a;
    logic       sck_b, ws_b, rise_b, fall_b, fs_b, run_b;
    logic [7:0] fp_b;
    logic [2:0] slot_b;

    int n_assert = 0;
    int n_fail   = 0;
    int ta  = 0;
    int tbt = 0;

    i2s_tdm_clock #(.CLK_DIV(4), .BITS_PER_SLOT(32), .SLOTS(2), .WS_MODE(WS_I2S)) dut_a (
        .ck(ck), .rst(rst), .en(en_a), .sck(sck_a), .ws(ws_a), .frame_posn(fp_a),
        .slot(slot_a), .sck_rise(rise_a), .sck_fall(fall_a), .frame_start(fs_a),
        .running(run_a)
    );

    i2s_tdm_clock #(.CLK_DIV(6), .BITS_PER_SLOT(32), .SLOTS(8), .WS_MODE(WS_PULSE)) dut_b (
        .ck(ck), .rst(rst), .en(en_b), .sck(sck_b), .ws(ws_b), .frame_posn(fp_b),
        .slot(slot_b), .sck_rise(rise_b), .sck_fall(fall_b), .frame_start(fs_b),
        .running(run_b)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    // Expected {running,sck,ws,sck_rise,sck_fall,frame_start,frame_posn} for the
    // div-4 stereo instance, t edges after its IDLE->RUN edge, en held high.
    function automatic logic [11:0] model_a(input int t);
        int p;
        logic [5:0] fp;
        if (t == 0) return {6'b100001, 6'd0};
        p  = t - 1;
        fp = 6'((t / 4) % 64);
        return {1'b1, (p % 4) >= 2, ((p / 4) % 64) >= 32, (p % 4) == 2,
                ((p % 4) == 0) && (t >= 2), (t >= 257) && ((p % 256) == 0), fp};
    endfunction

    // Same for the div-6 TDM-8 pulse instance (frame of 256 bits, 1536 cycles).
    function automatic logic [13:0] model_b(input int t);
        int p;
        logic [7:0] fp;
        if (t == 0) return {6'b100001, 8'd0};
        p  = t - 1;
        fp = 8'((t / 6) % 256);
        return {1'b1, (p % 6) >= 3, ((p / 6) % 256) == 255, (p % 6) == 3,
                ((p % 6) == 0) && (t >= 2), (t >= 1537) && ((p % 1536) == 0), fp};
    endfunction

    task automatic step();
        @(posedge ck);
        #1;
        ta++;
        tbt++;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        en_a = 1'b0;
        en_b = 1'b0;
        step();
        step();
        n_assert++;
        if ({run_a, sck_a, ws_a, rise_a, fall_a, fs_a, fp_a, slot_a} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_a: got %h want 0", {run_a, sck_a, ws_a, rise_a, fall_a, fs_a, fp_a, slot_a});
        end
        n_assert++;
        if ({run_b, sck_b, ws_b, rise_b, fall_b, fs_b, fp_b, slot_b} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_b: got %h want 0", {run_b, sck_b, ws_b, rise_b, fall_b, fs_b, fp_b, slot_b});
        end
        // en high while rst is asserted must not start the generator.
        en_a = 1'b1;
        step();
        n_assert++;
        if ({run_a, fs_a} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_priority: got run/fs %b want 00", {run_a, fs_a});
        end
    endtask

    task automatic test_startup();
        logic [5:0] exp_sig [6];
        logic [5:0] exp_fp  [6];
        exp_sig = '{6'b100001, 6'b100000, 6'b100000, 6'b110100, 6'b110000, 6'b100010};
        exp_fp  = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd1, 6'd1};
        rst = 1'b0;
        ta  = -1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_assert++;
            if ({run_a, sck_a, ws_a, rise_a, fall_a, fs_a, fp_a} !== {exp_sig[i], exp_fp[i]}) begin
                n_fail++;
                $display("FAIL startup_E%0d: got %b want %b", i,
                         {run_a, sck_a, ws_a, rise_a, fall_a, fs_a, fp_a}, {exp_sig[i], exp_fp[i]});
            end
        end
    endtask

    task automatic test_run_i2s();
        logic [11:0] e;
        while (ta < 3 * 256 + 8) begin
            step();
            e = model_a(ta);
            n_assert++;
            if ({run_a, sck_a, ws_a, rise_a, fall_a, fs_a, fp_a} !== e || slot_a !== e[5]) begin
                n_fail++;
                $display("FAIL run_i2s t=%0d: got %b/%b want %b/%b", ta,
                         {run_a, sck_a, ws_a, rise_a, fall_a, fs_a, fp_a}, slot_a, e, e[5]);
            end
        end
    endtask

    task automatic test_en_glitch();
        logic [11:0] e;
        bit found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            e = model_a(ta);
            n_assert++;
            if ({run_a, sck_a, ws_a, rise_a, fall_a, fs_a, fp_a} !== e) begin
                n_fail++;
                $display("FAIL glitch_pre t=%0d: got %b want %b", ta, {run_a, sck_a, ws_a, rise_a, fall_a, fs_a, fp_a}, e);
            end
            found = (fp_a == 6'd20);
        end
        n_assert++;
        if (!found) begin
            n_fail++;
            $display("FAIL glitch_wait: frame_posn never reached 20 (got %0d)", fp_a);
        end
        en_a = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (i == 8) en_a = 1'b1;
            step();
            e = model_a(ta);
            n_assert++;
            if ({run_a, sck_a, ws_a, rise_a, fall_a, fs_a, fp_a} !== e) begin
                n_fail++;
                $display("FAIL glitch t=%0d: got %b want %b", ta, {run_a, sck_a, ws_a, rise_a, fall_a, fs_a, fp_a}, e);
            end
        end
    endtask

    task automatic test_drain();
        logic [11:0] e;
        bit found = 0;
        int tw;
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            found = (fp_a == 6'd10);
        end
        n_assert++;
        if (!found) begin
            n_fail++;
            $display("FAIL drain_wait: frame_posn never reached 10 (got %0d)", fp_a);
        end
        en_a = 1'b0;
        tw   = (ta / 256 + 1) * 256;
        while (ta < tw + 3) begin
            step();
            if (ta < tw)            e = model_a(ta);
            else if (ta == tw)      e = {6'b011000, 6'd0};
            else if (ta == tw + 1)  e = {6'b000010, 6'd0};
            else                    e = 12'd0;
            n_assert++;
            if ({run_a, sck_a, ws_a, rise_a, fall_a, fs_a, fp_a} !== e) begin
                n_fail++;
                $display("FAIL drain t=%0d (wrap %0d): got %b want %b", ta, tw,
                         {run_a, sck_a, ws_a, rise_a, fall_a, fs_a, fp_a}, e);
            end
        end
    endtask

    task automatic test_rst_restart();
        logic [11:0] e;
        bit found = 0;
        en_a = 1'b1;
        ta   = -1;
        for (int i = 0; i < 400 && !found; i++) begin
            step();
            e = model_a(ta);
            n_assert++;
            if ({run_a, sck_a, ws_a, rise_a, fall_a, fs_a, fp_a} !== e) begin
                n_fail++;
                $display("FAIL rst_pre t=%0d: got %b want %b", ta, {run_a, sck_a, ws_a, rise_a, fall_a, fs_a, fp_a}, e);
            end
            found = (fp_a == 6'd40) && sck_a;
        end
        n_assert++;
        if (!found) begin
            n_fail++;
            $display("FAIL rst_wait: never saw frame_posn 40 with sck high (got %0d)", fp_a);
        end
        rst = 1'b1;
        step();
        n_assert++;
        if ({run_a, sck_a, ws_a, rise_a, fall_a, fs_a, fp_a, slot_a} !== 13'd0) begin
            n_fail++;
            $display("FAIL rst_mid: got %b want 0", {run_a, sck_a, ws_a, rise_a, fall_a, fs_a, fp_a, slot_a});
        end
        rst = 1'b0;
        ta  = -1;
        step();
        n_assert++;
        if ({run_a, sck_a, ws_a, rise_a, fall_a, fs_a, fp_a} !== {6'b100001, 6'd0}) begin
            n_fail++;
            $display("FAIL rst_restart: got %b want %b", {run_a, sck_a, ws_a, rise_a, fall_a, fs_a, fp_a}, {6'b100001, 6'd0});
        end
    endtask

    task automatic test_strobe_audit();
        logic prev;
        int   n_rise = 0;
        int   n_fall = 0;
        prev = sck_a;
        for (int i = 0; i < 2560; i++) begin
            step();
            n_assert++;
            if (rise_a !== (sck_a & ~prev) || fall_a !== (~sck_a & prev)) begin
                n_fail++;
                $display("FAIL strobe t=%0d: rise/fall %b%b want %b%b", ta, rise_a, fall_a,
                         sck_a & ~prev, ~sck_a & prev);
            end
            n_rise += int'(rise_a);
            n_fall += int'(fall_a);
            prev = sck_a;
        end
        n_assert++;
        if (n_rise != 640 || n_fall != 639) begin
            n_fail++;
            $display("FAIL strobe_count: rises %0d falls %0d want 640 639", n_rise, n_fall);
        end
    endtask

    task automatic test_pulse_tdm();
        logic [13:0] e;
        int   n_ws = 0;
        logic [2:0] max_slot = '0;
        en_b = 1'b1;
        tbt  = -1;
        for (int i = 0; i < 3083; i++) begin
            step();
            e = model_b(tbt);
            n_assert++;
            if ({run_b, sck_b, ws_b, rise_b, fall_b, fs_b, fp_b} !== e || slot_b !== e[7:5]) begin
                n_fail++;
                $display("FAIL pulse t=%0d: got %b/%0d want %b/%0d", tbt,
                         {run_b, sck_b, ws_b, rise_b, fall_b, fs_b, fp_b}, slot_b, e, e[7:5]);
            end
            n_ws += int'(ws_b);
            if (slot_b > max_slot) max_slot = slot_b;
        end
        n_assert++;
        if (n_ws != 12 || max_slot != 3'd7) begin
            n_fail++;
            $display("FAIL pulse_summary: ws cycles %0d max slot %0d want 12 7", n_ws, max_slot);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_run_i2s();
        test_en_glitch();
        test_drain();
        test_rst_restart();
        test_strobe_audit();
        test_pulse_tdm();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
